// File: rtl/mips_control_signal_register_scoreboard.sv
// Decode-stage register control: address/enable decode, in-flight write scoreboard,
// bypass selects and stall. Optional: MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN.
module mips_control_signal_register_scoreboard #(
    parameter  int unsigned ADDR_WIDTH     = 5,
    parameter  int unsigned DEPTH          = 3,
    parameter  int unsigned LOAD_READY_STG = 1,
    localparam int unsigned SEL_WIDTH      = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  issue_valid,
    input  logic                  is_func,
    input  logic                  cat_shift_reg,
    input  logic                  cat_link,
    input  logic                  cat_load,
    input  logic                  cat_store,
    input  logic                  cat_branch,
    input  logic                  cat_jump,
    input  logic                  port1_used,
    input  logic                  port2_used,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    input  logic [ADDR_WIDTH-1:0] rd,
    output logic [ADDR_WIDTH-1:0] port1_addr,
    output logic [ADDR_WIDTH-1:0] port2_addr,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic                  write_enable,
    output logic                  write_data_mem,
    output logic [SEL_WIDTH-1:0]  fwd1_sel,
    output logic [SEL_WIDTH-1:0]  fwd2_sel,
    output logic                  stall
);

`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
    localparam bit fwd_en = 1'b1;
`else
    localparam bit fwd_en = 1'b0;
`endif

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_load;
    logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];

    logic                  hit1, hit2;
    logic                  haz1, haz2;
    logic [SEL_WIDTH-1:0]  sel1, sel2;

    always_comb begin
        port1_addr = cat_shift_reg ? rt : rs;
        port2_addr = rt;
        if (cat_link) begin
            write_addr = '1;
        end else if (is_func) begin
            write_addr = rd;
        end else begin
            write_addr = rt;
        end
        write_enable   = issue_valid && !(cat_jump || cat_branch || cat_store) &&
                         (write_addr != '0);
        write_data_mem = cat_load;
    end

    // Youngest match wins: scan from stage 0 and latch only the first hit.
    // Without forwarding any hit is a hazard until the writer retires.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        haz1 = 1'b0;
        haz2 = 1'b0;
        sel1 = '0;
        sel2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!hit1 && port1_used && ent_valid[k] && (ent_addr[k] == port1_addr) &&
                (port1_addr != '0)) begin
                hit1 = 1'b1;
                sel1 = SEL_WIDTH'(k + 1);
                haz1 = fwd_en ? (ent_load[k] && (k < LOAD_READY_STG)) : 1'b1;
            end
            if (!hit2 && port2_used && ent_valid[k] && (ent_addr[k] == port2_addr) &&
                (port2_addr != '0)) begin
                hit2 = 1'b1;
                sel2 = SEL_WIDTH'(k + 1);
                haz2 = fwd_en ? (ent_load[k] && (k < LOAD_READY_STG)) : 1'b1;
            end
        end
    end

    always_comb begin
        stall    = issue_valid && (haz1 || haz2);
        fwd1_sel = (fwd_en && hit1 && !stall) ? sel1 : '0;
        fwd2_sel = (fwd_en && hit2 && !stall) ? sel2 : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_load  <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                ent_addr[k] <= '0;
            end
        end else if (advance) begin
            for (int unsigned k = 1; k < DEPTH; k++) begin
                ent_valid[k] <= ent_valid[k-1];
                ent_load[k]  <= ent_load[k-1];
                ent_addr[k]  <= ent_addr[k-1];
            end
            ent_valid[0] <= write_enable && !stall;
            ent_load[0]  <= cat_load;
            ent_addr[0]  <= write_addr;
        end
    end

endmodule

// File: tb/tb_mips_control_signal_register_scoreboard.sv
// Directed scoreboard bench for mips_control_signal_register_scoreboard (default parameters).
module tb_mips_control_signal_register_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       advance;
    logic       issue_valid, is_func, cat_shift_reg, cat_link, cat_load;
    logic       cat_store, cat_branch, cat_jump, port1_used, port2_used;
    logic [4:0] rs, rt, rd;
    logic [4:0] port1_addr, port2_addr, write_addr;
    logic       write_enable, write_data_mem, stall;
    logic [1:0] fwd1_sel, fwd2_sel;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic       valid, func, shreg, link, load, store, branch, jump, p1u, p2u;
        logic [4:0] rs, rt, rd;
    } instr_t;

    typedef struct {
        string       tag;
        logic [21:0] vec;
    } exp_t;

    exp_t exp_q[$];

    mips_control_signal_register_scoreboard dut (
        .clock          (clock),
        .reset          (reset),
        .advance        (advance),
        .issue_valid    (issue_valid),
        .is_func        (is_func),
        .cat_shift_reg  (cat_shift_reg),
        .cat_link       (cat_link),
        .cat_load       (cat_load),
        .cat_store      (cat_store),
        .cat_branch     (cat_branch),
        .cat_jump       (cat_jump),
        .port1_used     (port1_used),
        .port2_used     (port2_used),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .port1_addr     (port1_addr),
        .port2_addr     (port2_addr),
        .write_addr     (write_addr),
        .write_enable   (write_enable),
        .write_data_mem (write_data_mem),
        .fwd1_sel       (fwd1_sel),
        .fwd2_sel       (fwd2_sel),
        .stall          (stall)
    );

    always #5 clock = ~clock;

    function automatic instr_t f_nop();
        instr_t i = '0;
        return i;
    endfunction

    function automatic instr_t f_addu(input logic [4:0] d, input logic [4:0] s,
                                      input logic [4:0] t);
        instr_t i = '0;
        i.valid = 1'b1; i.func = 1'b1; i.p1u = 1'b1; i.p2u = 1'b1;
        i.rd = d; i.rs = s; i.rt = t;
        return i;
    endfunction

    function automatic instr_t f_sllv(input logic [4:0] d, input logic [4:0] t,
                                      input logic [4:0] s);
        instr_t i = f_addu(d, s, t);
        i.shreg = 1'b1;
        return i;
    endfunction

    function automatic instr_t f_lw(input logic [4:0] t, input logic [4:0] s);
        instr_t i = '0;
        i.valid = 1'b1; i.load = 1'b1; i.p1u = 1'b1; i.rt = t; i.rs = s;
        return i;
    endfunction

    function automatic instr_t f_ori(input logic [4:0] t, input logic [4:0] s);
        instr_t i = '0;
        i.valid = 1'b1; i.p1u = 1'b1; i.rt = t; i.rs = s;
        return i;
    endfunction

    function automatic instr_t f_sw(input logic [4:0] t, input logic [4:0] s);
        instr_t i = '0;
        i.valid = 1'b1; i.store = 1'b1; i.p1u = 1'b1; i.p2u = 1'b1; i.rt = t; i.rs = s;
        return i;
    endfunction

    function automatic instr_t f_beq(input logic [4:0] s, input logic [4:0] t);
        instr_t i = '0;
        i.valid = 1'b1; i.branch = 1'b1; i.p1u = 1'b1; i.p2u = 1'b1; i.rs = s; i.rt = t;
        return i;
    endfunction

    function automatic instr_t f_jal();
        instr_t i = '0;
        i.valid = 1'b1; i.link = 1'b1;
        return i;
    endfunction

    task automatic drive(input instr_t ins, input logic adv);
        advance       = adv;
        issue_valid   = ins.valid;
        is_func       = ins.func;
        cat_shift_reg = ins.shreg;
        cat_link      = ins.link;
        cat_load      = ins.load;
        cat_store     = ins.store;
        cat_branch    = ins.branch;
        cat_jump      = ins.jump;
        port1_used    = ins.p1u;
        port2_used    = ins.p2u;
        rs            = ins.rs;
        rt            = ins.rt;
        rd            = ins.rd;
    endtask

    // Called at posedge+1: drive, push expectation, compare at negedge, return at next posedge+1.
    task automatic apply(input string tag, input instr_t ins, input logic adv, input logic st,
                         input logic [1:0] f1, input logic [1:0] f2, input logic we,
                         input logic wdm, input logic [4:0] wa, input logic [4:0] p1,
                         input logic [4:0] p2);
        exp_t        e;
        logic [21:0] obs;
        drive(ins, adv);
        exp_q.push_back('{tag, {st, f1, f2, we, wdm, wa, p1, p2}});
        @(negedge clock);
        obs = {stall, fwd1_sel, fwd2_sel, write_enable, write_data_mem, write_addr,
               port1_addr, port2_addr};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.vec) else begin
                miscompares++;
                $error("FAIL %s observed {stall,f1,f2,we,wdm,wa,p1,p2}=%h expected=%h",
                       e.tag, obs, e.vec);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) begin
            apply("nop", f_nop(), 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drive(f_nop(), 1'b1);
        repeat (2) @(posedge clock);
        #1;
        // Decode follows inputs while reset holds selects and stall at zero.
        apply("rst_dec", f_addu(6, 5, 5), 1, 0, 0, 0, 1, 0, 6, 5, 5);
        reset = 1'b0;

        // ALU writer then dependent reader on both ports.
        apply("t2_wr", f_addu(5, 1, 2), 1, 0, 0, 0, 1, 0, 5, 1, 2);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        apply("t2_fwd", f_addu(6, 5, 5), 1, 0, 1, 1, 1, 0, 6, 5, 5);
`else
        repeat (3) apply("t2_stall", f_addu(6, 5, 5), 1, 1, 0, 0, 1, 0, 6, 5, 5);
        apply("t2_rf", f_addu(6, 5, 5), 1, 0, 0, 0, 1, 0, 6, 5, 5);
`endif
        nops(3);

        // Load-use.
        apply("t3_lw", f_lw(5, 1), 1, 0, 0, 0, 1, 1, 5, 1, 5);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        apply("t3_stall", f_addu(6, 5, 0), 1, 1, 0, 0, 1, 0, 6, 5, 0);
        apply("t3_fwd", f_addu(6, 5, 0), 1, 0, 2, 0, 1, 0, 6, 5, 0);
`else
        repeat (3) apply("t3_stall", f_addu(6, 5, 0), 1, 1, 0, 0, 1, 0, 6, 5, 0);
        apply("t3_rf", f_addu(6, 5, 0), 1, 0, 0, 0, 1, 0, 6, 5, 0);
`endif
        nops(3);

        // Two writers of $5 in flight; youngest must win.
        apply("t4_ori", f_ori(5, 1), 1, 0, 0, 0, 1, 0, 5, 1, 5);
        apply("t4_addu", f_addu(5, 2, 3), 1, 0, 0, 0, 1, 0, 5, 2, 3);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        apply("t4_young", f_addu(7, 5, 0), 1, 0, 1, 0, 1, 0, 7, 5, 0);
`else
        repeat (3) apply("t4_stall", f_addu(7, 5, 0), 1, 1, 0, 0, 1, 0, 7, 5, 0);
        apply("t4_rf", f_addu(7, 5, 0), 1, 0, 0, 0, 1, 0, 7, 5, 0);
`endif
        nops(3);

        // Non-writers are not tracked; jal writes $31.
        apply("t5_sw", f_sw(8, 1), 1, 0, 0, 0, 0, 0, 8, 1, 8);
        apply("t5_rd_sw", f_addu(0, 31, 0), 1, 0, 0, 0, 0, 0, 0, 31, 0);
        apply("t5_beq", f_beq(1, 2), 1, 0, 0, 0, 0, 0, 2, 1, 2);
        apply("t5_rd_beq", f_addu(0, 31, 0), 1, 0, 0, 0, 0, 0, 0, 31, 0);
        apply("t5_zero", f_addu(0, 1, 2), 1, 0, 0, 0, 0, 0, 0, 1, 2);
        apply("t5_rd_zero", f_addu(0, 31, 0), 1, 0, 0, 0, 0, 0, 0, 31, 0);
        apply("t5_jal", f_jal(), 1, 0, 0, 0, 1, 0, 31, 0, 0);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        apply("t5_rd_jal", f_addu(0, 31, 0), 1, 0, 1, 0, 0, 0, 0, 31, 0);
`else
        repeat (3) apply("t5_stall_jal", f_addu(0, 31, 0), 1, 1, 0, 0, 0, 0, 0, 31, 0);
        apply("t5_rd_jal", f_addu(0, 31, 0), 1, 0, 0, 0, 0, 0, 0, 31, 0);
`endif
        nops(3);

        // Shift-by-register port mapping, then freeze with advance=0.
        apply("t6_sllv", f_sllv(4, 7, 9), 1, 0, 0, 0, 1, 0, 4, 7, 7);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        repeat (2) apply("t6_hold", f_addu(8, 4, 4), 0, 0, 1, 1, 1, 0, 8, 4, 4);
        apply("t6_adv", f_addu(8, 4, 4), 1, 0, 1, 1, 1, 0, 8, 4, 4);
        apply("t6_adv2", f_addu(8, 4, 4), 1, 0, 2, 2, 1, 0, 8, 4, 4);
`else
        repeat (2) apply("t6_hold", f_addu(8, 4, 4), 0, 1, 0, 0, 1, 0, 8, 4, 4);
        repeat (3) apply("t6_adv_stall", f_addu(8, 4, 4), 1, 1, 0, 0, 1, 0, 8, 4, 4);
        apply("t6_rf", f_addu(8, 4, 4), 1, 0, 0, 0, 1, 0, 8, 4, 4);
`endif
        nops(3);

        // Fill three entries, then reset mid-run.
        apply("t1_w5", f_addu(5, 1, 2), 1, 0, 0, 0, 1, 0, 5, 1, 2);
        apply("t1_w6", f_addu(6, 1, 2), 1, 0, 0, 0, 1, 0, 6, 1, 2);
        apply("t1_w7", f_addu(7, 1, 2), 1, 0, 0, 0, 1, 0, 7, 1, 2);
`ifdef MIPS_CONTROL_SIGNAL_REGISTER_SCOREBOARD_FORWARD_EN
        apply("t1_pre", f_addu(8, 5, 0), 1, 0, 3, 0, 1, 0, 8, 5, 0);
`else
        apply("t1_pre", f_addu(8, 5, 0), 1, 1, 0, 0, 1, 0, 8, 5, 0);
`endif
        reset = 1'b1;
        apply("t1_in_rst", f_addu(8, 7, 6), 1, 0, 0, 0, 1, 0, 8, 7, 6);
        reset = 1'b0;
        apply("t1_after", f_addu(9, 5, 0), 1, 0, 0, 0, 1, 0, 9, 5, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
